// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between two writeback
//   requesters (A: execute, B: load/multi-cycle). Each requester owns a
//   one-entry holding slot with a valid/ready handshake; an age-aware
//   round-robin arbiter drains one slot per cycle into registered write-port
//   outputs. Also publishes a per-register pending-write scoreboard.
// Ports:
//   Clk, ResetL              clock (rising edge), async active-low reset
//   A_Valid/A_Ready/A_Rd/A_Data  requester A handshake, destination, data
//   B_Valid/B_Ready/B_Rd/B_Data  requester B handshake, destination, data
//   RegWr, RW, BusW          registered write enable / address / data
//   Pending                  bit r set while a write to register r is held or issuing
module regfile_write_arbiter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                    Clk,
  input  logic                    ResetL,
  input  logic                    A_Valid,
  output logic                    A_Ready,
  input  logic [ADDR_W-1:0]       A_Rd,
  input  logic [DATA_W-1:0]       A_Data,
  input  logic                    B_Valid,
  output logic                    B_Ready,
  input  logic [ADDR_W-1:0]       B_Rd,
  input  logic [DATA_W-1:0]       B_Data,
  output logic                    RegWr,
  output logic [ADDR_W-1:0]       RW,
  output logic [DATA_W-1:0]       BusW,
  output logic [(1<<ADDR_W)-1:0]  Pending
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  typedef enum logic {FAV_A, FAV_B} rr_t;

  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_rd, b_rd;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_older, older_d;
  rr_t               rr_q, rr_d;
  logic              gnt_a, gnt_b;
  logic              a_load, b_load;

  // Same destination uses age so write-after-write order holds; otherwise
  // the round-robin pointer decides and flips.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    rr_d  = rr_q;
    if (a_full && b_full) begin
      if (a_rd == b_rd) begin
        if (a_older) gnt_a = 1'b1;
        else         gnt_b = 1'b1;
      end else if (rr_q == FAV_A) begin
        gnt_a = 1'b1;
        rr_d  = FAV_B;
      end else begin
        gnt_b = 1'b1;
        rr_d  = FAV_A;
      end
    end else if (a_full) begin
      gnt_a = 1'b1;
    end else if (b_full) begin
      gnt_b = 1'b1;
    end
  end

  assign A_Ready = ResetL && (!a_full || gnt_a);
  assign B_Ready = ResetL && (!b_full || gnt_b);

  // Zero-register requests complete the handshake but never occupy a slot.
  assign a_load = A_Valid && A_Ready && (A_Rd != ZERO_ADDR);
  assign b_load = B_Valid && B_Ready && (B_Rd != ZERO_ADDR);

  // The flag only matters while both slots are full; it is set whenever a
  // load makes both full without the other slot draining.
  always_comb begin
    older_d = a_older;
    if (a_load && b_load)                older_d = 1'b1;
    else if (a_load && b_full && !gnt_b) older_d = 1'b0;
    else if (b_load && a_full && !gnt_a) older_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      a_full  <= 1'b0;
      b_full  <= 1'b0;
      a_rd    <= '0;
      b_rd    <= '0;
      a_data  <= '0;
      b_data  <= '0;
      a_older <= 1'b0;
      rr_q    <= FAV_A;
    end else begin
      a_older <= older_d;
      rr_q    <= rr_d;
      if (a_load) begin
        a_full <= 1'b1;
        a_rd   <= A_Rd;
        a_data <= A_Data;
      end else if (gnt_a) begin
        a_full <= 1'b0;
      end
      if (b_load) begin
        b_full <= 1'b1;
        b_rd   <= B_Rd;
        b_data <= B_Data;
      end else if (gnt_b) begin
        b_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      RegWr <= 1'b0;
      RW    <= '0;
      BusW  <= '0;
    end else begin
      RegWr <= gnt_a || gnt_b;
      if (gnt_a) begin
        RW   <= a_rd;
        BusW <= a_data;
      end else if (gnt_b) begin
        RW   <= b_rd;
        BusW <= b_data;
      end
    end
  end

  always_comb begin
    Pending = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      Pending[r] = (a_full && (a_rd == ADDR_W'(r))) ||
                   (b_full && (b_rd == ADDR_W'(r))) ||
                   (RegWr  && (RW   == ADDR_W'(r)));
    end
    Pending[ZERO_REG] = 1'b0;
  end

endmodule
